// File: rtl/fp_bin2bcd_seq_pkg.sv
// Shared constants, state encoding and the double-dabble adjust helper for the
// fixed-point binary to BCD converter.
package fp_bin2bcd_seq_pkg;

    localparam int unsigned INT_BITS  = 20;
    localparam int unsigned FRAC_BITS = 20;
    localparam int unsigned INT_DIG   = 6;
    localparam int unsigned FRAC_DIG  = 6;

    // Integer BCD carries one extra digit so 1048575 fits before saturation.
    localparam int unsigned IBCD_W = (INT_DIG + 1) * 4;
    localparam int unsigned FBCD_W = FRAC_DIG * 4;
    localparam int unsigned OUT_W  = (INT_DIG + FRAC_DIG) * 4;

    localparam logic [OUT_W-1:0] BCD_SAT   = 48'h999999_999999;
    localparam logic [4:0]       INT_LAST  = 5'(INT_BITS - 1);
    localparam logic [4:0]       FRAC_LAST = 5'(FRAC_DIG);

    typedef enum logic [2:0] {
        StIdle,
        StInt,
        StFrac,
        StRnd,
        StDone
    } state_e;

    function automatic logic [IBCD_W-1:0] add3_adj(input logic [IBCD_W-1:0] v);
        logic [IBCD_W-1:0] r;
        r = v;
        for (int i = 0; i < INT_DIG + 1; i++) begin
            if (r[4*i +: 4] >= 4'd5) r[4*i +: 4] = r[4*i +: 4] + 4'd3;
        end
        return r;
    endfunction

endpackage

// File: rtl/fp_bin2bcd_seq_bcd_inc13.sv
// Combinational 13-digit BCD increment; each 9 wraps to 0 and carries onward.
module bcd_inc13 (
    input  logic [51:0] din,
    output logic [51:0] dout
);

    logic carry;

    always_comb begin
        dout  = din;
        carry = 1'b1;
        for (int i = 0; i < 13; i++) begin
            if (carry) begin
                if (din[4*i +: 4] == 4'd9) begin
                    dout[4*i +: 4] = 4'd0;
                end else begin
                    dout[4*i +: 4] = din[4*i +: 4] + 4'd1;
                    carry          = 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/fp_bin2bcd_seq.sv
// Iterative Q20.20 unsigned binary to 12-digit packed BCD with half-up rounding
// on the 7th fraction digit and saturation above 999999.
module fp_bin2bcd_seq
    import fp_bin2bcd_seq_pkg::*;
(
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [INT_BITS+FRAC_BITS-1:0] fp_bin,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [OUT_W-1:0]             fp_bcd,
    output logic                         ovf
);

    state_e                state_q, state_d;
    logic [4:0]            cnt_q;
    logic [INT_BITS-1:0]   ireg_q;
    logic [FRAC_BITS-1:0]  freg_q;
    logic [IBCD_W-1:0]     ibcd_q;
    logic [FBCD_W-1:0]     fbcd_q;
    logic [3:0]            rnd_dig_q;
    logic [OUT_W-1:0]      fp_bcd_q;
    logic                  ovf_q;

    logic [IBCD_W+INT_BITS-1:0] int_shift;
    logic [FRAC_BITS+3:0]       prod;
    logic [IBCD_W+FBCD_W-1:0]   inc_sum;
    logic [IBCD_W+FBCD_W-1:0]   rounded;
    logic                       sat;

    assign int_shift = {add3_adj(ibcd_q), ireg_q} << 1;
    assign prod      = {4'd0, freg_q} * 24'd10;
    assign rounded   = (rnd_dig_q >= 4'd5) ? inc_sum : {ibcd_q, fbcd_q};
    assign sat       = (rounded[IBCD_W+FBCD_W-1 -: 4] != 4'd0);

    bcd_inc13 u_inc (
        .din  ({ibcd_q, fbcd_q}),
        .dout (inc_sum)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (in_valid) state_d = StInt;
            StInt:   if (cnt_q == INT_LAST) state_d = StFrac;
            StFrac:  if (cnt_q == FRAC_LAST) state_d = StRnd;
            StRnd:   state_d = StDone;
            StDone:  if (out_ready) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            ireg_q    <= '0;
            freg_q    <= '0;
            ibcd_q    <= '0;
            fbcd_q    <= '0;
            rnd_dig_q <= '0;
            fp_bcd_q  <= '0;
            ovf_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        ireg_q    <= fp_bin[INT_BITS+FRAC_BITS-1:FRAC_BITS];
                        freg_q    <= fp_bin[FRAC_BITS-1:0];
                        ibcd_q    <= '0;
                        fbcd_q    <= '0;
                        rnd_dig_q <= '0;
                        cnt_q     <= '0;
                    end
                end
                StInt: begin
                    ibcd_q <= int_shift[IBCD_W+INT_BITS-1:INT_BITS];
                    ireg_q <= int_shift[INT_BITS-1:0];
                    cnt_q  <= (cnt_q == INT_LAST) ? 5'd0 : cnt_q + 5'd1;
                end
                StFrac: begin
                    freg_q <= prod[FRAC_BITS-1:0];
                    // First six digits are exported; the seventh only steers rounding.
                    if (cnt_q < FRAC_LAST) fbcd_q <= {fbcd_q[FBCD_W-5:0], prod[FRAC_BITS+3:FRAC_BITS]};
                    else                   rnd_dig_q <= prod[FRAC_BITS+3:FRAC_BITS];
                    cnt_q <= (cnt_q == FRAC_LAST) ? 5'd0 : cnt_q + 5'd1;
                end
                StRnd: begin
                    fp_bcd_q <= sat ? BCD_SAT : rounded[OUT_W-1:0];
                    ovf_q    <= sat;
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign out_valid = (state_q == StDone);
    assign fp_bcd    = fp_bcd_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_fp_bin2bcd_seq.sv
// Directed self-checking bench for fp_bin2bcd_seq.
module tb_fp_bin2bcd_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [39:0] fp_bin;
    logic        out_valid;
    logic        out_ready;
    logic [47:0] fp_bcd;
    logic        ovf;

    int n_cmp = 0;
    int n_err = 0;

    fp_bin2bcd_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .fp_bin    (fp_bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .fp_bcd    (fp_bcd),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Accept v, wait for the result, optionally stall delivery for 'hold' cycles.
    task automatic convert(input string tag, input logic [39:0] v, input logic [47:0] exp_bcd,
                           input logic exp_ovf, input int hold);
        int n;
        @(negedge clk);
        check({tag, " in_ready"}, 64'(in_ready), 64'd1);
        in_valid = 1'b1;
        fp_bin   = v;
        @(negedge clk);
        in_valid = 1'b0;
        fp_bin   = 40'hAAAAA_55555;
        n = 0;
        while (!out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        check({tag, " latency"}, 64'(n), 64'd28);
        check({tag, " fp_bcd"}, 64'(fp_bcd), 64'(exp_bcd));
        check({tag, " ovf"}, 64'(ovf), 64'(exp_ovf));
        if (hold > 0) begin
            in_valid = 1'b1;
            fp_bin   = 40'h00007_00000;
            for (int i = 0; i < hold; i++) begin
                @(negedge clk);
                check({tag, " hold out_valid"}, 64'(out_valid), 64'd1);
                check({tag, " hold in_ready"}, 64'(in_ready), 64'd0);
                check({tag, " hold fp_bcd"}, 64'(fp_bcd), 64'(exp_bcd));
            end
            in_valid = 1'b0;
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, " delivered out_valid"}, 64'(out_valid), 64'd0);
        check({tag, " idle in_ready"}, 64'(in_ready), 64'd1);
        check({tag, " idle fp_bcd held"}, 64'(fp_bcd), 64'(exp_bcd));
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        fp_bin    = '0;
        repeat (2) @(negedge clk);
        check("reset in_ready", 64'(in_ready), 64'd1);
        check("reset out_valid", 64'(out_valid), 64'd0);
        check("reset fp_bcd", 64'(fp_bcd), 64'd0);
        check("reset ovf", 64'(ovf), 64'd0);
        rst_n = 1'b1;

        convert("zero", 40'h00000_00000, 48'h000000_000000, 1'b0, 0);
        convert("3.25", 40'h00003_40000, 48'h000003_250000, 1'b0, 0);
        convert("round_up", 40'h00001_00001, 48'h000001_000001, 1'b0, 0);
        convert("small_round", 40'h00000_00008, 48'h000000_000008, 1'b0, 0);
        convert("0.1", 40'h00000_1999A, 48'h000000_100000, 1'b0, 0);
        convert("12345.75", 40'h03039_C0000, 48'h012345_750000, 1'b0, 0);
        convert("max_nosat", 40'hF423F_FFFFF, 48'h999999_999999, 1'b0, 0);
        convert("sat", 40'hF4240_00000, 48'h999999_999999, 1'b1, 0);
        convert("hold", 40'h00002_80000, 48'h000002_500000, 1'b0, 5);

        // A request raised during the stall must not have been taken.
        @(negedge clk);
        check("hold no stray accept", 64'(out_valid), 64'd0);

        // Abort mid-conversion with reset.
        @(negedge clk);
        in_valid = 1'b1;
        fp_bin   = 40'h00123_45678;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort in_ready", 64'(in_ready), 64'd1);
        check("abort out_valid", 64'(out_valid), 64'd0);
        check("abort fp_bcd", 64'(fp_bcd), 64'd0);
        check("abort ovf", 64'(ovf), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        convert("after_reset", 40'h00000_80000, 48'h000000_500000, 1'b0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
